// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative EX-stage multiply/divide unit with HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle over WIDTH iterations, followed by a sign-fix/writeback cycle.
// Launch handshake: the unit is ready exactly when busy=0 (state IDLE). A
// start seen on a rising edge while ready is accepted on that edge. A start
// seen while busy=1 is dropped rather than queued, so the issuing stage must
// hold the instruction until busy falls.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             kill,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic               div_q;     // 1: divide in flight, 0: multiply
  logic               neg_x_q;   // product sign, or quotient sign for divide
  logic               neg_r_q;   // remainder sign (sign of dividend)
  logic               dbz_q;     // divide by zero captured at launch
  logic [WIDTH-1:0]   a_raw_q;   // dividend as presented, for divide by zero
  logic [WIDTH-1:0]   opnd_q;    // multiplicand magnitude or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;     // product accumulator / dividend-quotient shifter
  logic [WIDTH-1:0]   rem_q;     // partial remainder between iterations
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Launch-time operand decode
  logic             is_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Per-iteration datapath and writeback values
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: kill aborts RUN/FIX, FIX always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (kill)               state_d = S_IDLE;
        else if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand decode and iteration arithmetic
  always_comb begin
    is_div = op[1];
    a_neg  = op[0] & operand_a[WIDTH-1];
    b_neg  = op[0] & operand_b[WIDTH-1];
    mag_a  = a_neg ? (~operand_a + 1'b1) : operand_a;
    mag_b  = b_neg ? (~operand_b + 1'b1) : operand_b;

    // Shift-add: conditionally add the multiplicand into the upper half,
    // then shift the whole accumulator (and its carry) right by one.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, trial-subtract the
    // divisor in WIDTH+1 bits, keep the difference when it is non-negative.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];

    prod_fix = neg_x_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_x_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Datapath: capture at launch, iterate in RUN, write HI/LO in FIX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_x_q <= 1'b0;
      neg_r_q <= 1'b0;
      dbz_q   <= 1'b0;
      a_raw_q <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            cnt_q   <= '0;
            div_q   <= is_div;
            neg_x_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            dbz_q   <= is_div && (operand_b == '0);
            a_raw_q <= operand_a;
            opnd_q  <= is_div ? mag_b : mag_a;
            acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            rem_q   <= '0;
          end
        end
        S_RUN: begin
          if (!kill) begin
            cnt_q <= cnt_q + CW'(1);
            if (div_q) begin
              rem_q            <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], div_ge};
            end else begin
              acc_q <= mul_next;
            end
          end
        end
        S_FIX: begin
          if (!kill) begin
            done_q <= 1'b1;
            if (!div_q) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else if (dbz_q) begin
              hi_q <= a_raw_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random mul/div operations. Expected HI/LO
// pairs are queued at launch and compared on each done pulse.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, kill, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] operand_a, operand_b, wdata;
  logic [W-1:0] hi_out, lo_out;
  logic         busy, done;
  logic [1:0]   state_dbg;

  logic [63:0] exp_q[$];
  logic [63:0] last_exp = '0;
  string       cur_tag = "none";
  int          n_checks = 0;
  int          n_fail = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .kill(kill),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {HI, LO} built from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, m;
    logic [63:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    r  = '0;
    case (o)
      2'b00: r = {32'b0, a} * {32'b0, b};
      2'b01: r = sa * sb;
      2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset && done) begin
      if (exp_q.size() == 0) check("unexpected_done", {63'b0, done}, 64'd0);
      else check({cur_tag, "_result"}, {hi_out, lo_out}, exp_q.pop_front());
    end
  end

  // Launch one op and follow it to done. wr0 adds an MTLO in the launch
  // cycle; we_at / st_at inject an MTLO / a second start at that cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] e,
                        input bit wr0, input int we_at, input int st_at);
    int lat, bcnt;
    exp_q.push_back(e);
    last_exp  = e;
    cur_tag   = tag;
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    if (wr0) begin
      lo_we = 1'b1;
      wdata = 32'h1111;
    end
    @(posedge clock); #1;
    start = 1'b0;
    lo_we = 1'b0;
    if (wr0) check({tag, "_mtlo_at_launch"}, {32'b0, lo_out}, 64'h1111);
    lat  = 1;
    bcnt = 0;
    while (lat < 60) begin
      @(negedge clock);
      if (done) break;
      if (busy) bcnt++;
      @(posedge clock); #1;
      lat++;
      lo_we = (lat == we_at);
      wdata = 32'hAAAA;
      start = (lat == st_at);
      if (lat == st_at) begin
        op        = 2'b00;
        operand_a = 32'h2;
        operand_b = 32'h3;
      end
    end
    lo_we = 1'b0;
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, {63'b0, done}, 64'd0);
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] v);
    hi_we = to_hi;
    lo_we = !to_hi;
    wdata = v;
    @(posedge clock); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (to_hi) last_exp[63:32] = v;
    else       last_exp[31:0]  = v;
    check(to_hi ? "mthi_idle" : "mtlo_idle", {hi_out, lo_out}, last_exp);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b0; start = 1'b0; kill = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; operand_a = '0; operand_b = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    check("reset_busy_done", {62'b0, busy, done}, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed results
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 0);
    run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 0);
    run_op("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, 0);
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0);
    run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0, 0);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 0, 0);
    run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, 0);
    run_op("divu_by0", 2'b10, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 0, 0, 0);
    run_op("div_neg_by0", 2'b11, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 0, 0, 0);

    // MTHI/MTLO in IDLE
    mt_write(1'b1, 32'hDEAD_BEEF);
    mt_write(1'b0, 32'h0BAD_F00D);

    // MTLO at cycle 5 and a second start at cycle 10 of a run: both ignored
    run_op("busy_ignores", 2'b01, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 0, 5, 10);
    repeat (2) @(posedge clock);
    #1;
    check("no_relaunch_busy", {63'b0, busy}, 64'd0);

    // MTLO in the launch cycle: write lands, FIX later overwrites HI/LO
    run_op("mtlo_with_start", 2'b10, 32'd50, 32'd5, 64'h0000_0000_0000_000A, 1, 0, 0);

    // Kill at cycle 20: busy drops next cycle, no done, HI/LO unchanged
    cur_tag   = "kill";
    op        = 2'b00;
    operand_a = 32'd123;
    operand_b = 32'd456;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clock); #1;
    end
    kill = 1'b1;
    @(posedge clock); #1;
    kill = 1'b0;
    check("kill_busy", {63'b0, busy}, 64'd0);
    check("kill_no_done", {63'b0, done}, 64'd0);
    repeat (40) @(posedge clock);
    #1;
    check("kill_hilo_kept", {hi_out, lo_out}, last_exp);

    // Asynchronous reset at cycle 15 of a run
    cur_tag   = "reset_mid";
    op        = 2'b00;
    operand_a = 32'hFFFF_FFFF;
    operand_b = 32'hFFFF_FFFF;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int c = 1; c < 15; c++) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("async_reset_hilo", {hi_out, lo_out}, 64'd0);
    check("async_reset_busy_done", {62'b0, busy, done}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    exp_q.delete();
    last_exp = '0;
    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 64'd42, 0, 0, 0);

    // Random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2) ? 32'($urandom_range(1, 100)) : $urandom);
      if (i % 3 == 0) begin
        ra = -32'($urandom_range(0, 1000));
        rb = -32'($urandom_range(1, 50));
      end
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb), 0, 0, 0);
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage, consuming operands and control registered by the ID/EX pipeline register. It executes MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers, and accepts direct MTHI/MTLO writes. It raises `busy` so hazard control can stall dependent MFHI/MFLO or back-to-back mul/div instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request, sampled on a rising edge only while in IDLE.
- `op`  in  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `operand_a`  in  WIDTH  multiplicand or dividend, driven from ID/EX operand 1.
- `operand_b`  in  WIDTH  multiplier or divisor, driven from ID/EX operand 2.
- `kill`  in  1  abort the in-flight operation (branch or exception flush).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi_out`  out  WIDTH  HI register.
- `lo_out`  out  WIDTH  LO register.
- `busy`  out  1  high while state is not IDLE.
- `done`  out  1  one-cycle pulse when HI/LO take a new mul/div result.

## Operation
- States:
  - IDLE
  - RUN: 32 iterations, 5-bit counter.
  - FIX: sign correction and writeback.
- Capture at launch:
  - IDLE with `start`=1 latches the op.
  - Operand magnitudes are latched: absolute value for signed ops, raw value for unsigned.
  - Result sign: for MULT, sign(a) XOR sign(b). For DIV, quotient sign is sign(a) XOR sign(b) and remainder sign is sign(a).
  - Counter is cleared.
- Multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- Divide: restoring, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
- FIX:
  - Negates the result halves (two's complement) where the sign flag requires it.
  - Multiply: writes the 64-bit product as HI = upper, LO = lower.
  - Divide: writes LO = quotient, HI = remainder.
  - Pulses `done` and returns to IDLE.
- Signed division:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives LO = 0x80000000, HI = 0 with no fault.
- Divide by zero (defined behaviour): LO = 0xFFFFFFFF, HI = operand_a as captured. For DIV, `operand_a` is used unmodified. Latency is unchanged.
- `start` outside IDLE is ignored. Hazard control must stall the instruction while `busy`=1.
- `kill`:
  - In RUN or FIX, returns to IDLE on the next edge.
  - HI/LO are not written and `done` is not pulsed.
  - Takes priority over FIX writeback.
  - In IDLE, `kill` has no effect.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; HI/LO update on the next edge.
  - Ignored in RUN/FIX.
  - If `start` and a write enable arrive in the same IDLE cycle, the write completes and the operation also launches; its FIX later overwrites both HI and LO.
- Reset (`reset`=0, any time including mid-operation):
  - State IDLE, counter 0.
  - `hi_out`, `lo_out`, internal accumulators = 0.
  - `busy` = 0, `done` = 0.
  - Effect is immediate, not waiting for a clock edge.

## Timing
- Edge E0 samples `start` in IDLE: `busy` rises after E0.
- Edges E1–E32 perform the iterations; state enters FIX after E32.
- Edge E33 writes HI/LO, returns to IDLE, and drops `busy`.
- `done` = 1 for the single cycle after E33. New HI/LO are visible in that same cycle.
- Total: 34 cycles from the `start` cycle to the first cycle with valid results.
- A new `start` is accepted in the cycle `done` is high (state is IDLE). The earliest relaunch is therefore at E34.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. `done` pulses exactly 34 cycles after `start`; `busy` is high for 33 cycles.
- MULT −3 × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 -> LO = 14, HI = 2. DIV 0x80000000 / −1 -> LO = 0x80000000, HI = 0.
- DIVU 0x1234 / 0 -> LO = 0xFFFFFFFF, HI = 0x1234 after 34 cycles.
- MTLO 0xAAAA while busy: ignored, LO holds its result. Second `start` at cycle 10 of a run: ignored.
- `kill` at cycle 20 of a run: `busy` drops next cycle, no `done`, HI/LO keep prior values.
- `reset` pulsed low at cycle 15 of a run: `busy`, `done`, HI, LO are all 0 immediately. A fresh MULTU 6 × 7 then yields LO = 42, HI = 0.
